// File: rtl/sha256_padder_if.sv
// Byte-stream input and 512-bit block output of the SHA-256 message padder.
// The slave modport is the padder; the master modport is its byte source and block sink.
interface sha256_padder_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;

    modport master (
        output in_data, in_valid, in_last, blk_ready,
        input  in_ready, blk, blk_valid, blk_last
    );

    modport slave (
        input  in_data, in_valid, in_last, blk_ready,
        output in_ready, blk, blk_valid, blk_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: buffers a byte stream, appends 0x80, zero fill and the
// 64-bit big-endian bit length, and emits complete 512-bit blocks (byte 0 in [511:504]).
module sha256_padder #(
    parameter int LEN_W = 61
) (
    input  logic             CLK,
    input  logic             nreset,
    sha256_padder_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_ACCEPT  = 3'd0,
        ST_PAD_80  = 3'd1,
        ST_PAD_Z   = 3'd2,
        ST_PAD_LEN = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

    state_t             state_q;
    state_t             resume_q;
    logic               final_q;
    logic [5:0]         idx_q;
    logic [LEN_W-1:0]   count_q;
    logic [511:0]       buf_q;
    logic               in_ready_q;
    logic               blk_valid_q;
    logic               blk_last_q;

    logic [7:0]         pad_byte_s;
    logic [63:0]        bit_len_s;
    logic [8:0]         byte_lsb_s;

    assign pad_byte_s = (state_q == ST_PAD_80) ? 8'h80 : 8'h00;
    assign bit_len_s  = 64'({count_q, 3'b000});
    // Byte idx sits at bit 8*(63-idx); 63-idx is simply the 6-bit complement.
    assign byte_lsb_s = {~idx_q, 3'b000};

    // Framing FSM: buffer, padding writes, block hand-off and registered handshake outputs.
    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_ACCEPT;
            resume_q    <= ST_ACCEPT;
            final_q     <= 1'b0;
            idx_q       <= 6'd0;
            count_q     <= '0;
            buf_q       <= 512'd0;
            in_ready_q  <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (bus.in_valid) begin
                        buf_q[byte_lsb_s +: 8] <= bus.in_data;
                        idx_q   <= idx_q + 6'd1;
                        count_q <= count_q + {{(LEN_W-1){1'b0}}, 1'b1};
                        if (idx_q == 6'd63) begin
                            state_q     <= ST_EMIT;
                            final_q     <= 1'b0;
                            resume_q    <= bus.in_last ? ST_PAD_80 : ST_ACCEPT;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            blk_last_q  <= 1'b0;
                        end else if (bus.in_last) begin
                            state_q    <= ST_PAD_80;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_ACCEPT;
                        end
                    end else begin
                        state_q <= ST_ACCEPT;
                    end
                end
                ST_PAD_80, ST_PAD_Z: begin
                    buf_q[byte_lsb_s +: 8] <= pad_byte_s;
                    idx_q <= idx_q + 6'd1;
                    if (idx_q == 6'd55) begin
                        state_q <= ST_PAD_LEN;
                    end else if (idx_q == 6'd63) begin
                        // No room for the length: flush this block and pad a fresh one.
                        state_q     <= ST_EMIT;
                        final_q     <= 1'b0;
                        resume_q    <= ST_PAD_Z;
                        blk_valid_q <= 1'b1;
                        blk_last_q  <= 1'b0;
                    end else begin
                        state_q <= ST_PAD_Z;
                    end
                end
                ST_PAD_LEN: begin
                    buf_q[63:0] <= bit_len_s;
                    state_q     <= ST_EMIT;
                    final_q     <= 1'b1;
                    blk_valid_q <= 1'b1;
                    blk_last_q  <= 1'b1;
                end
                ST_EMIT: begin
                    if (bus.blk_ready) begin
                        blk_valid_q <= 1'b0;
                        blk_last_q  <= 1'b0;
                        idx_q       <= 6'd0;
                        if (final_q) begin
                            count_q    <= '0;
                            state_q    <= ST_ACCEPT;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q    <= resume_q;
                            in_ready_q <= (resume_q == ST_ACCEPT);
                        end
                    end else begin
                        state_q <= ST_EMIT;
                    end
                end
                default: begin
                    state_q     <= ST_ACCEPT;
                    idx_q       <= 6'd0;
                    in_ready_q  <= 1'b1;
                    blk_valid_q <= 1'b0;
                    blk_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.blk       = buf_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: short, block-spanning and full-block messages,
// backpressure, back-to-back messages and reset during padding.
module tb_sha256_padder;

    logic CLK = 1'b0;
    logic nreset;
    sha256_padder_if bus ();

    sha256_padder #(.LEN_W(61)) dut (
        .CLK    (CLK),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   msg_q[$];
    logic [511:0] got_blk;
    logic         got_last;
    int           got_lat;
    logic         rdy_idle = 1'b0;
    logic [511:0] exp_abc;
    logic [511:0] exp_b1;
    logic [511:0] exp_b2;
    logic [511:0] snap;
    string        s56;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_abc();
        msg_q = {};
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    task automatic send_msg(input int max_gap);
        for (int i = 0; i < msg_q.size(); i++) begin
            int gap;
            int cyc;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.in_valid = 1'b0;
            repeat (gap) begin @(posedge CLK); #1; end
            bus.in_data  = msg_q[i];
            bus.in_last  = (i == msg_q.size() - 1);
            bus.in_valid = 1'b1;
            cyc = 0;
            while (!bus.in_ready && cyc < 300) begin @(posedge CLK); #1; cyc++; end
            if (!bus.in_ready) chk("in_ready_tmo", 512'(bus.in_ready), 512'd1);
            @(posedge CLK); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        got_lat = 0;
        while (!bus.blk_valid && got_lat < 300) begin @(posedge CLK); #1; got_lat++; end
        if (!bus.blk_valid) chk("blk_tmo", 512'(bus.blk_valid), 512'd1);
    endtask

    task automatic get_block();
        wait_valid();
        got_blk  = bus.blk;
        got_last = bus.blk_last;
        bus.blk_ready = 1'b1;
        @(posedge CLK); #1;
        chk("vfall", 512'(bus.blk_valid), 512'd0);
        bus.blk_ready = rdy_idle;
    endtask

    initial begin
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.blk_ready = 1'b0;
        nreset = 1'b0;
        exp_abc = 512'd0;
        exp_abc[511:480] = 32'h61626380;
        exp_abc[63:0]    = 64'h18;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", 512'(bus.blk_valid), 512'd0);
        chk("rst_last",  512'(bus.blk_last),  512'd0);
        chk("rst_blk",   bus.blk,             512'd0);
        chk("rst_ready", 512'(bus.in_ready),  512'd1);
        nreset = 1'b1;
        @(posedge CLK); #1;

        // "abc"
        load_abc();
        send_msg(0);
        get_block();
        chk("abc_lat",  512'(got_lat),  512'd54);
        chk("abc_blk",  got_blk,        exp_abc);
        chk("abc_last", 512'(got_last), 512'd1);

        // 56-byte message: length spills into a second block
        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg_q = {};
        exp_b1 = 512'd0;
        for (int i = 0; i < s56.len(); i++) begin
            msg_q.push_back(s56[i]);
            exp_b1[511 - 8*i -: 8] = s56[i];
        end
        exp_b1[511 - 8*56 -: 8] = 8'h80;
        exp_b2 = 512'd0;
        exp_b2[63:0] = 64'h1C0;
        send_msg(0);
        get_block();
        chk("m56_b1",   got_blk,        exp_b1);
        chk("m56_b1_l", 512'(got_last), 512'd0);
        get_block();
        chk("m56_b2",   got_blk,        exp_b2);
        chk("m56_b2_l", 512'(got_last), 512'd1);

        // 64 zero bytes: full block, then 0x80 at byte 0 of the next
        msg_q = {};
        for (int i = 0; i < 64; i++) msg_q.push_back(8'h00);
        exp_b2 = 512'd0;
        exp_b2[511:504] = 8'h80;
        exp_b2[63:0]    = 64'h200;
        send_msg(0);
        get_block();
        chk("z64_lat",  512'(got_lat),  512'd0);
        chk("z64_b1",   got_blk,        512'd0);
        chk("z64_b1_l", 512'(got_last), 512'd0);
        get_block();
        chk("z64_b2",   got_blk,        exp_b2);
        chk("z64_b2_l", 512'(got_last), 512'd1);

        // Backpressure with input gaps and a stalled block sink
        load_abc();
        send_msg(3);
        wait_valid();
        snap = bus.blk;
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        repeat (10) begin @(posedge CLK); #1; end
        chk("bp_stable", bus.blk,             snap);
        chk("bp_ready",  512'(bus.in_ready),  512'd0);
        chk("bp_valid",  512'(bus.blk_valid), 512'd1);
        bus.in_valid = 1'b0;
        get_block();
        chk("bp_blk", got_blk, exp_abc);
        load_abc();
        send_msg(0);
        get_block();
        chk("bp_next", got_blk, exp_abc);

        // Back-to-back with blk_ready held high
        rdy_idle = 1'b1;
        bus.blk_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load_abc();
            send_msg(0);
            get_block();
            chk("b2b_blk",  got_blk,        exp_abc);
            chk("b2b_last", 512'(got_last), 512'd1);
        end
        rdy_idle = 1'b0;
        bus.blk_ready = 1'b0;

        // Reset while zero-filling
        load_abc();
        send_msg(0);
        repeat (10) begin @(posedge CLK); #1; end
        chk("pre_rst_ready", 512'(bus.in_ready), 512'd0);
        nreset = 1'b0;
        #1;
        chk("mid_rst_valid", 512'(bus.blk_valid), 512'd0);
        chk("mid_rst_ready", 512'(bus.in_ready),  512'd1);
        chk("mid_rst_blk",   bus.blk,             512'd0);
        @(posedge CLK); #1;
        nreset = 1'b1;
        @(posedge CLK); #1;
        load_abc();
        send_msg(0);
        get_block();
        chk("post_rst_lat", 512'(got_lat), 512'd54);
        chk("post_rst_blk", got_blk,       exp_abc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
